// File: rtl/button_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// button_conditioner_pkg
//
// Purpose:
//   Shared definitions for the push-button conditioner: the debounce FSM state
//   encoding and the helper that derives the idle (released) pin level from the
//   button polarity.
//
// Contents:
//   state_e         - 2-bit FSM state encoding used by button_conditioner.
//   released_level  - pin level seen while the button is not pressed.
// -----------------------------------------------------------------------------
package button_conditioner_pkg;

    // The encoding is fixed so that state values stay stable when they are
    // probed on a debug bus or compared across design revisions.
    typedef enum logic [1:0] {
        RELEASED   = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } state_e;

    // An active-low button idles high, an active-high button idles low.
    // The synchroniser resets to this value so that leaving reset never looks
    // like a press.
    function automatic logic released_level(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

endpackage : button_conditioner_pkg

// File: rtl/button_conditioner_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//
// Purpose:
//   One-bit, two-flop synchroniser that brings an asynchronous level into the
//   clk domain. The reset value is a parameter so the flops can idle at
//   whatever level the source rests at.
//
// Ports:
//   clk   in  1  destination clock
//   rstn  in  1  asynchronous active-low reset
//   d_i   in  1  asynchronous input level
//   q_o   out 1  synchronised level (two clk edges of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // First flop may go metastable; the second gives it a full cycle to
    // resolve before anything downstream looks at the value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Purpose:
//   Turns a raw, bouncing, asynchronous push-button pin into clean control
//   signals for the LED pattern generator. A short press toggles the reverse
//   level; a long press produces a single long_pulse (image switch request)
//   and leaves reverse alone.
//
// Parameters:
//   DEBOUNCE_SIZE    debounce counter width; a level must be stable for
//                    2^DEBOUNCE_SIZE cycles before it is accepted.
//   LONG_PRESS_SIZE  hold counter width; a press becomes "long" after
//                    2^LONG_PRESS_SIZE-1 cycles held past the accepted press.
//   ACTIVE_LOW       1 when the pin reads 0 while pressed.
//
// Ports:
//   clk            in  1  system clock
//   rstn           in  1  asynchronous active-low reset
//   btn            in  1  raw button pin (asynchronous, bouncing)
//   btn_state      out 1  debounced pressed level (1 = pressed)
//   press_pulse    out 1  one-cycle pulse on each debounced press
//   release_pulse  out 1  one-cycle pulse on each debounced release
//   long_pulse     out 1  one-cycle pulse when the hold reaches the threshold
//   reverse        out 1  direction level, toggled by each short press
// -----------------------------------------------------------------------------
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_SIZE   = 15,
    parameter int LONG_PRESS_SIZE = 22,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic btn,
    output logic btn_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic reverse
);

    localparam logic RELEASED_LEVEL = released_level(ACTIVE_LOW);

    localparam logic [DEBOUNCE_SIZE-1:0]   DB_MAX   = '1;
    localparam logic [DEBOUNCE_SIZE-1:0]   DB_ONE   = {{(DEBOUNCE_SIZE-1){1'b0}}, 1'b1};
    localparam logic [LONG_PRESS_SIZE-1:0] HOLD_MAX = '1;
    localparam logic [LONG_PRESS_SIZE-1:0] HOLD_ONE = {{(LONG_PRESS_SIZE-1){1'b0}}, 1'b1};

    // -------------------------------------------------------------------------
    // Synchronised, polarity-normalised button level
    // -------------------------------------------------------------------------
    logic btn_sync;
    logic pressed_s;

    sync_2ff #(
        .RESET_VALUE (RELEASED_LEVEL)
    ) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d_i  (btn),
        .q_o  (btn_sync)
    );

    assign pressed_s = btn_sync ^ ACTIVE_LOW;

    // -------------------------------------------------------------------------
    // State, counters and registered outputs
    // -------------------------------------------------------------------------
    state_e                     state_q,         state_d;
    logic [DEBOUNCE_SIZE-1:0]   db_cnt_q,        db_cnt_d;
    logic [LONG_PRESS_SIZE-1:0] hold_cnt_q,      hold_cnt_d;
    logic                       long_fired_q,    long_fired_d;
    logic                       btn_state_q,     btn_state_d;
    logic                       press_pulse_q,   press_pulse_d;
    logic                       release_pulse_q, release_pulse_d;
    logic                       long_pulse_q,    long_pulse_d;
    logic                       reverse_q,       reverse_d;

    logic [LONG_PRESS_SIZE-1:0] hold_inc;
    logic                       long_hit;

    // Hold counter saturates rather than wraps so a very long hold can never
    // re-reach the threshold and fire a second long_pulse.
    // long_hit looks at the value the counter is about to take, so the pulse
    // leaves on the same edge the counter reaches its maximum.
    always_comb begin
        hold_inc = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HOLD_ONE;
        long_hit = (hold_inc == HOLD_MAX) && !long_fired_q;
    end

    // All state lives here and is cleared asynchronously, so a reset in the
    // middle of a press throws the press away and puts reverse back to 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= RELEASED;
            db_cnt_q        <= '0;
            hold_cnt_q      <= '0;
            long_fired_q    <= 1'b0;
            btn_state_q     <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_pulse_q    <= 1'b0;
            reverse_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            db_cnt_q        <= db_cnt_d;
            hold_cnt_q      <= hold_cnt_d;
            long_fired_q    <= long_fired_d;
            btn_state_q     <= btn_state_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            long_pulse_q    <= long_pulse_d;
            reverse_q       <= reverse_d;
        end
    end

    // Next-state and output logic.
    // The two DB_* states each run the debounce counter from zero on entry;
    // any sample that disagrees with the level being qualified sends the FSM
    // straight back, which is how bounces are rejected.
    // The hold counter keeps running through DB_RELEASE so that a release
    // bounce does not restart the long-press timer.
    // A long press that completes on the very edge the release is accepted
    // still counts as long, so reverse stays put in that case.
    always_comb begin
        state_d         = state_q;
        db_cnt_d        = db_cnt_q;
        hold_cnt_d      = hold_cnt_q;
        long_fired_d    = long_fired_q;
        btn_state_d     = btn_state_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        long_pulse_d    = 1'b0;
        reverse_d       = reverse_q;

        unique case (state_q)
            RELEASED: begin
                if (pressed_s) begin
                    state_d  = DB_PRESS;
                    db_cnt_d = '0;
                end
            end

            DB_PRESS: begin
                if (!pressed_s) begin
                    state_d = RELEASED;
                end else if (db_cnt_q == DB_MAX) begin
                    state_d       = PRESSED;
                    press_pulse_d = 1'b1;
                    btn_state_d   = 1'b1;
                    hold_cnt_d    = '0;
                    long_fired_d  = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end

            PRESSED: begin
                hold_cnt_d = hold_inc;
                if (long_hit) begin
                    long_pulse_d = 1'b1;
                    long_fired_d = 1'b1;
                end
                if (!pressed_s) begin
                    state_d  = DB_RELEASE;
                    db_cnt_d = '0;
                end
            end

            DB_RELEASE: begin
                hold_cnt_d = hold_inc;
                if (long_hit) begin
                    long_pulse_d = 1'b1;
                    long_fired_d = 1'b1;
                end
                if (pressed_s) begin
                    state_d = PRESSED;
                end else if (db_cnt_q == DB_MAX) begin
                    state_d         = RELEASED;
                    btn_state_d     = 1'b0;
                    release_pulse_d = 1'b1;
                    if (!long_fired_q && !long_hit) begin
                        reverse_d = !reverse_q;
                    end
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end

            default: begin
                state_d = RELEASED;
            end
        endcase
    end

    assign btn_state     = btn_state_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign long_pulse    = long_pulse_q;
    assign reverse       = reverse_q;

endmodule : button_conditioner
